// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch front end: one outstanding imem request, held instruction
// handed to decode, next PC from branch resolution on acceptance.
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                IMM_W    = 26
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              decode_ready,
    input  logic              Branch,
    input  logic              unconditional_branch,
    input  logic              zero,
    input  logic [IMM_W-1:0]  br_offset,
    output logic [31:0]       retired_count
);

    typedef enum logic {
        S_REQ,
        S_HOLD
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              req_q;
    logic              valid_q;
    logic              taken;
    logic [ADDR_W-1:0] offset_bytes;
    logic [ADDR_W-1:0] next_pc;

    // Word offset sign-extended and scaled to bytes keeps pc word aligned.
    assign offset_bytes = {{(ADDR_W-IMM_W-2){br_offset[IMM_W-1]}},
                           br_offset, 2'b00};
    assign taken   = unconditional_branch | (Branch & zero);
    assign next_pc = taken ? instr_pc + offset_bytes
                           : instr_pc + ADDR_W'(4);

    assign imem_req    = req_q;
    assign imem_addr   = pc;
    assign instr_valid = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_REQ;
            pc            <= RESET_PC;
            req_q         <= 1'b0;
            valid_q       <= 1'b0;
            instr_out     <= '0;
            instr_pc      <= '0;
            retired_count <= '0;
        end else begin
            unique case (state)
                S_REQ: begin
                    // req_q low only in the bubble right after reset.
                    if (req_q && imem_ready) begin
                        instr_out <= imem_rdata;
                        instr_pc  <= pc;
                        req_q     <= 1'b0;
                        valid_q   <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (decode_ready) begin
                        pc            <= next_pc;
                        retired_count <= retired_count + 32'd1;
                        req_q         <= 1'b1;
                        valid_q       <= 1'b0;
                        state         <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed corner cases
// followed by randomized imem latency, decode stalls and branches.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_out;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        decode_ready = 1'b0;
    logic        Branch = 1'b0;
    logic        unconditional_branch = 1'b0;
    logic        zero = 1'b0;
    logic [25:0] br_offset = '0;
    logic [31:0] retired_count;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ready           (imem_ready),
        .imem_rdata           (imem_rdata),
        .instr_out            (instr_out),
        .instr_pc             (instr_pc),
        .instr_valid          (instr_valid),
        .decode_ready         (decode_ready),
        .Branch               (Branch),
        .unconditional_branch (unconditional_branch),
        .zero                 (zero),
        .br_offset            (br_offset),
        .retired_count        (retired_count)
    );

    typedef struct {
        logic [31:0] data;
        logic [63:0] pc;
    } instr_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] ret;
    } req_t;

    instr_t exp_instr[$];
    req_t   exp_req[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_pc;
    logic [63:0] m_ipc;
    logic [31:0] m_ret;
    bit          last_hs;
    bit          last_acc;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst          = 1'b1;
            imem_ready   = 1'b1;
            decode_ready = 1'b1;
            exp_instr.delete();
            exp_req.delete();
            m_pc  = 64'd0;
            m_ipc = 64'd0;
            m_ret = 32'd0;
            exp_req.push_back('{64'd0, 32'd0});
        end
    endtask

    task automatic step(input bit r, input logic [31:0] d, input bit dr,
                        input bit b, input bit u, input bit z,
                        input logic [25:0] off);
        longint so;
        @(negedge clk);
        rst                  = 1'b0;
        imem_ready           = r;
        imem_rdata           = d;
        decode_ready         = dr;
        Branch               = b;
        unconditional_branch = u;
        zero                 = z;
        br_offset            = off;
        last_hs  = imem_req && r;
        last_acc = instr_valid && dr;
        if (last_hs) begin
            exp_instr.push_back('{d, m_pc});
            m_ipc = m_pc;
        end
        if (last_acc) begin
            so = longint'(signed'(off));
            if (u || (b && z))
                m_pc = m_ipc + 64'(so * 4);
            else
                m_pc = m_ipc + 64'd4;
            m_ret++;
            exp_req.push_back('{m_pc, m_ret});
        end
    endtask

    task automatic fetch(input logic [31:0] d);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0);
            if (last_hs) return;
        end
        check("fetch_timeout", 64'd0, 64'd1);
    endtask

    task automatic accept(input bit b, input bit u, input bit z,
                          input logic [25:0] off);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'd0, 1'b1, b, u, z, off);
            if (last_acc) return;
        end
        check("accept_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: compares DUT outputs against scoreboard queues.
    bit          prev_req   = 1'b0;
    bit          prev_valid = 1'b0;
    logic [63:0] hold_addr;
    logic [31:0] held_out;
    logic [63:0] held_pc;

    always @(posedge clk) begin
        req_t   rq;
        instr_t iq;
        #1;
        if (rst) begin
            check("rst_req", 64'(imem_req), 64'd0);
            check("rst_valid", 64'(instr_valid), 64'd0);
            check("rst_retired", 64'(retired_count), 64'd0);
            prev_req   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (imem_req && !prev_req) begin
                if (exp_req.size() == 0) begin
                    check("req_unexpected", 64'd1, 64'd0);
                end else begin
                    rq = exp_req.pop_front();
                    check("req_addr", imem_addr, rq.addr);
                    check("retired", 64'(retired_count), 64'(rq.ret));
                end
                hold_addr = imem_addr;
            end else if (imem_req) begin
                check("addr_stable", imem_addr, hold_addr);
            end
            if (instr_valid && !prev_valid) begin
                if (exp_instr.size() == 0) begin
                    check("valid_unexpected", 64'd1, 64'd0);
                end else begin
                    iq = exp_instr.pop_front();
                    check("instr_out", 64'(instr_out), 64'(iq.data));
                    check("instr_pc", instr_pc, iq.pc);
                end
                held_out = instr_out;
                held_pc  = instr_pc;
            end else if (instr_valid) begin
                check("hold_out", 64'(instr_out), 64'(held_out));
                check("hold_pc", instr_pc, held_pc);
            end
            if (instr_valid)
                check("hold_no_req", 64'(imem_req), 64'd0);
            prev_req   = imem_req;
            prev_valid = instr_valid;
        end
    end

    initial begin
        do_reset(2);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0);
        fetch(32'h8B02_0020);
        accept(1'b0, 1'b0, 1'b0, 26'd0);
        fetch($urandom);
        accept(1'b0, 1'b1, 1'b0, 26'd3);
        fetch($urandom);
        accept(1'b1, 1'b0, 1'b1, 26'h3FF_FFFE);
        fetch($urandom);
        accept(1'b0, 1'b1, 1'b0, 26'd2);
        fetch($urandom);
        accept(1'b1, 1'b0, 1'b0, 26'h3FF_FFFE);
        fetch($urandom);
        accept(1'b0, 1'b1, 1'b0, 26'h3B);
        fetch($urandom);
        accept(1'b1, 1'b1, 1'b0, 26'h3FF_FFFF);
        fetch($urandom);
        for (int i = 0; i < 5; i++)
            step(1'b1, $urandom, 1'b0, 1'($urandom), 1'($urandom),
                 1'($urandom), 26'($urandom));
        accept(1'b0, 1'b0, 1'b0, 26'd0);
        fetch($urandom);
        accept(1'b0, 1'b1, 1'b0, 26'h10);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0);
        do_reset(1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0);
        fetch($urandom);
        accept(1'b0, 1'b1, 1'b0, 26'h3FF_FFFF);
        fetch($urandom);
        accept(1'b0, 1'b0, 1'b0, 26'd0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0)
                do_reset(1 + $urandom_range(0, 1));
            else
                step($urandom_range(0, 2) != 0, $urandom,
                     $urandom_range(0, 2) != 0, 1'($urandom),
                     $urandom_range(0, 3) == 0, 1'($urandom),
                     26'($urandom));
        end
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0);
        check("drain_req_q", 64'(exp_req.size()), 64'd0);
        check("drain_instr_q", 64'(exp_instr.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
